control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 55 +++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer_t_state_counter.sv | 19 +
 rtl/control_sequencer.sv | 104 ++++++++++
 tb/tb_control_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the microcoded control sequencer: opcodes, T-state
// encoding and the packed control word with its all-inactive value.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } tstate_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JZ  = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic pc_inc;
        logic n_pc_enable;
        logic n_pc_load;
        logic n_mar_load;
        logic n_ram_enable;
        logic n_ir_load;
        logic n_ir_enable;
        logic n_a_load;
        logic a_enable;
        logic alu_sub;
        logic alu_enable;
        logic n_b_load;
        logic n_out_load;
    } ctrl_t;

    // Active-low strobes parked high, active-high strobes parked low.
    localparam ctrl_t CTRL_INACTIVE = '{
        pc_inc:       1'b0,
        n_pc_enable:  1'b1,
        n_pc_load:    1'b1,
        n_mar_load:   1'b1,
        n_ram_enable: 1'b1,
        n_ir_load:    1'b1,
        n_ir_enable:  1'b1,
        n_a_load:     1'b1,
        a_enable:     1'b0,
        alu_sub:      1'b0,
        alu_enable:   1'b0,
        n_b_load:     1'b1,
        n_out_load:   1'b1
    };

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-side inputs and control-word outputs of the sequencer.
// The sequencer uses the slave view; the instruction/datapath side uses master.
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       pc_inc;
    logic       n_pc_enable;
    logic       n_pc_load;
    logic       n_mar_load;
    logic       n_ram_enable;
    logic       n_ir_load;
    logic       n_ir_enable;
    logic       n_a_load;
    logic       a_enable;
    logic       alu_sub;
    logic       alu_enable;
    logic       n_b_load;
    logic       n_out_load;
    logic       halted;
    logic [2:0] t_state;

    modport master (
        output opcode, zero_flag,
        input  pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable,
               n_ir_load, n_ir_enable, n_a_load, a_enable, alu_sub,
               alu_enable, n_b_load, n_out_load, halted, t_state
    );

    modport slave (
        input  opcode, zero_flag,
        output pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable,
               n_ir_load, n_ir_enable, n_a_load, a_enable, alu_sub,
               alu_enable, n_b_load, n_out_load, halted, t_state
    );
endinterface

// File: rtl/control_sequencer_t_state_counter.sv
// Six-state ring counter T1..T6 with a hold input (used by HLT) and a
// synchronous active-low clear.
module t_state_counter
    import control_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    n_clear,
    input  logic    hold,
    output tstate_t t_state
);

    always_ff @(posedge clk) begin
        if (!n_clear)
            t_state <= T1;
        else if (!hold)
            t_state <= (t_state == T6) ? T1 : tstate_t'(t_state + 3'd1);
    end

endmodule

// File: rtl/control_sequencer.sv
// Six-T-state control sequencer: fetch in T1-T3, opcode-specific execute in
// T4-T6, with all control strobes decoded combinationally from the T-state.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              n_clear,
    control_sequencer_if.slave bus
);

    tstate_t t_state;
    ctrl_t   ctrl;
    logic    halted_q;
    logic    hlt_now;

    t_state_counter u_t_state_counter (
        .clk     (clk),
        .n_clear (n_clear),
        .hold    (halted_q | hlt_now),
        .t_state (t_state)
    );

    // Halt latches on the first T4 of HLT so later opcode changes cannot unfreeze it.
    always_ff @(posedge clk) begin
        if (!n_clear)
            halted_q <= 1'b0;
        else if (hlt_now)
            halted_q <= 1'b1;
    end

    always_comb begin
        ctrl    = CTRL_INACTIVE;
        hlt_now = 1'b0;
        if (n_clear && !halted_q) begin
            case (t_state)
                T1: begin ctrl.n_pc_enable  = 1'b0; ctrl.n_mar_load = 1'b0; end
                T2: ctrl.pc_inc = 1'b1;
                T3: begin ctrl.n_ram_enable = 1'b0; ctrl.n_ir_load  = 1'b0; end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.n_ir_enable = 1'b0;
                            ctrl.n_mar_load  = 1'b0;
                        end
                        OP_JMP: begin
                            ctrl.n_ir_enable = 1'b0;
                            ctrl.n_pc_load   = 1'b0;
                        end
                        OP_JZ: begin
                            ctrl.n_ir_enable = ~bus.zero_flag;
                            ctrl.n_pc_load   = ~bus.zero_flag;
                        end
                        OP_OUT: begin
                            ctrl.a_enable   = 1'b1;
                            ctrl.n_out_load = 1'b0;
                        end
                        OP_HLT:  hlt_now = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl.n_ram_enable = 1'b0;
                            ctrl.n_a_load     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.n_ram_enable = 1'b0;
                            ctrl.n_b_load     = 1'b0;
                            ctrl.alu_sub      = (bus.opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    // alu_sub stays up through the write-back so the result is settled.
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        ctrl.alu_enable = 1'b1;
                        ctrl.n_a_load   = 1'b0;
                        ctrl.alu_sub    = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_inc       = ctrl.pc_inc;
    assign bus.n_pc_enable  = ctrl.n_pc_enable;
    assign bus.n_pc_load    = ctrl.n_pc_load;
    assign bus.n_mar_load   = ctrl.n_mar_load;
    assign bus.n_ram_enable = ctrl.n_ram_enable;
    assign bus.n_ir_load    = ctrl.n_ir_load;
    assign bus.n_ir_enable  = ctrl.n_ir_enable;
    assign bus.n_a_load     = ctrl.n_a_load;
    assign bus.a_enable     = ctrl.a_enable;
    assign bus.alu_sub      = ctrl.alu_sub;
    assign bus.alu_enable   = ctrl.alu_enable;
    assign bus.n_b_load     = ctrl.n_b_load;
    assign bus.n_out_load   = ctrl.n_out_load;
    assign bus.halted       = n_clear & (halted_q | hlt_now);
    assign bus.t_state      = t_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute control words per opcode,
// HLT freeze, reset behaviour and a random single-bus-driver sweep.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic n_clear;
    int   errors = 0;
    int   checks = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk     (clk),
        .n_clear (n_clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {pc_inc,n_pc_enable,n_pc_load,n_mar_load,n_ram_enable,n_ir_load,
    //  n_ir_enable,n_a_load,a_enable,alu_sub,alu_enable,n_b_load,n_out_load}
    localparam logic [12:0] W_INACT = 13'b0_1_1_1_1_1_1_1_0_0_0_1_1;
    localparam logic [12:0] W_T1    = 13'b0_0_1_0_1_1_1_1_0_0_0_1_1;
    localparam logic [12:0] W_T2    = 13'b1_1_1_1_1_1_1_1_0_0_0_1_1;
    localparam logic [12:0] W_T3    = 13'b0_1_1_1_0_0_1_1_0_0_0_1_1;
    localparam logic [12:0] W_ADDR  = 13'b0_1_1_0_1_1_0_1_0_0_0_1_1;
    localparam logic [12:0] W_LDA5  = 13'b0_1_1_1_0_1_1_0_0_0_0_1_1;
    localparam logic [12:0] W_ADD5  = 13'b0_1_1_1_0_1_1_1_0_0_0_0_1;
    localparam logic [12:0] W_SUB5  = 13'b0_1_1_1_0_1_1_1_0_1_0_0_1;
    localparam logic [12:0] W_ADD6  = 13'b0_1_1_1_1_1_1_0_0_0_1_1_1;
    localparam logic [12:0] W_SUB6  = 13'b0_1_1_1_1_1_1_0_0_1_1_1_1;
    localparam logic [12:0] W_JMP4  = 13'b0_1_0_1_1_1_0_1_0_0_0_1_1;
    localparam logic [12:0] W_OUT4  = 13'b0_1_1_1_1_1_1_1_1_0_0_1_0;

    function automatic logic [12:0] word();
        return {bus.pc_inc, bus.n_pc_enable, bus.n_pc_load, bus.n_mar_load,
                bus.n_ram_enable, bus.n_ir_load, bus.n_ir_enable, bus.n_a_load,
                bus.a_enable, bus.alu_sub, bus.alu_enable, bus.n_b_load, bus.n_out_load};
    endfunction

    function automatic int bus_sources();
        return int'(!bus.n_pc_enable) + int'(!bus.n_ram_enable) + int'(!bus.n_ir_enable)
             + int'(bus.a_enable) + int'(bus.alu_enable);
    endfunction

    task automatic test_reset();
        n_clear = 1'b0;
        bus.opcode = 4'b0001;
        bus.zero_flag = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.t_state !== 3'd0) begin
            errors++; $display("FAIL reset_tstate: got %0d want 0", bus.t_state);
        end
        checks++;
        if (word() !== W_INACT || bus.halted !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %b halted=%b want %b halted=0", word(), bus.halted, W_INACT);
        end
        n_clear = 1'b1;
        #1;
    endtask

    // Each instruction test starts #1 after the negedge of a T1 cycle.
    task automatic test_lda();
        logic [12:0] exp [6];
        exp = '{W_T1, W_T2, W_T3, W_ADDR, W_LDA5, W_INACT};
        bus.opcode = 4'b1111;  // garbage during fetch must not matter
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin bus.opcode = 4'b0000; #0; end
            checks++;
            if (word() !== exp[i] || bus.t_state !== 3'(i)) begin
                errors++; $display("FAIL lda_T%0d: got %b t=%0d want %b t=%0d", i + 1, word(), bus.t_state, exp[i], i);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (bus.t_state !== 3'd0 || word() !== W_T1) begin
            errors++; $display("FAIL lda_wrap: got %b t=%0d want %b t=0", word(), bus.t_state, W_T1);
        end
    endtask

    task automatic test_arith(input logic [3:0] op, input logic [12:0] w5, input logic [12:0] w6, input string nm);
        logic [12:0] exp [6];
        exp = '{W_T1, W_T2, W_T3, W_ADDR, w5, w6};
        bus.opcode = op;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (word() !== exp[i] || bus.t_state !== 3'(i)) begin
                errors++; $display("FAIL %s_T%0d: got %b t=%0d want %b t=%0d", nm, i + 1, word(), bus.t_state, exp[i], i);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_jz_jmp_out_nop();
        logic [12:0] exp [6];
        logic [3:0]  ops [5];
        logic        zfs [5];
        logic [12:0] w4s [5];
        ops = '{4'b0011, 4'b0100, 4'b0100, 4'b1110, 4'b0101};
        zfs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        w4s = '{W_JMP4, W_JMP4, W_INACT, W_OUT4, W_INACT};
        for (int k = 0; k < 5; k++) begin
            bus.opcode = ops[k];
            bus.zero_flag = zfs[k];
            exp = '{W_T1, W_T2, W_T3, w4s[k], W_INACT, W_INACT};
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (word() !== exp[i] || bus.t_state !== 3'(i)) begin
                    errors++; $display("FAIL op%b_zf%b_T%0d: got %b t=%0d want %b t=%0d", ops[k], zfs[k], i + 1, word(), bus.t_state, exp[i], i);
                end
                @(negedge clk); #1;
            end
        end
        bus.zero_flag = 1'b0;
    endtask

    task automatic test_halt();
        bus.opcode = 4'b1111;
        repeat (3) begin @(negedge clk); #1; end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) bus.opcode = 4'b0001;  // frozen regardless of opcode
            checks++;
            if (bus.t_state !== 3'd3 || bus.halted !== 1'b1 || word() !== W_INACT) begin
                errors++; $display("FAIL halt_hold_%0d: got t=%0d halted=%b %b want t=3 halted=1 %b", i, bus.t_state, bus.halted, word(), W_INACT);
            end
            @(negedge clk); #1;
        end
        n_clear = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.t_state !== 3'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_clear: got t=%0d halted=%b want t=0 halted=0", bus.t_state, bus.halted);
        end
        n_clear = 1'b1;
        #1;
        checks++;
        if (word() !== W_T1) begin
            errors++; $display("FAIL halt_restart: got %b want %b", word(), W_T1);
        end
    endtask

    task automatic test_reset_mid_add();
        bus.opcode = 4'b0001;
        repeat (4) begin @(negedge clk); #1; end
        checks++;
        if (bus.t_state !== 3'd4 || word() !== W_ADD5) begin
            errors++; $display("FAIL midreset_T5: got %b t=%0d want %b t=4", word(), bus.t_state, W_ADD5);
        end
        n_clear = 1'b0;
        #1;
        checks++;
        if (word() !== W_INACT) begin
            errors++; $display("FAIL midreset_comb: got %b want %b", word(), W_INACT);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.t_state !== 3'd0 || word() !== W_INACT || bus.n_a_load !== 1'b1) begin
            errors++; $display("FAIL midreset_edge: got %b t=%0d want %b t=0", word(), bus.t_state, W_INACT);
        end
        n_clear = 1'b1;
        #1;
        checks++;
        if (word() !== W_T1 || bus.t_state !== 3'd0) begin
            errors++; $display("FAIL midreset_release: got %b t=%0d want %b t=0", word(), bus.t_state, W_T1);
        end
    endtask

    task automatic test_random_bus();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            bus.zero_flag = 1'($urandom_range(0, 1));
            #1;
            if (bus_sources() > 1) begin
                bad++;
                if (bad <= 5) $display("FAIL bus_contention_%0d: got %0d sources want <=1", i, bus_sources());
            end
            @(negedge clk); #1;
            // Clear any HLT so the sweep keeps exercising all T-states.
            if (bus.halted) begin
                n_clear = 1'b0; @(negedge clk); n_clear = 1'b1; #1;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bus_single_driver: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_arith(4'b0001, W_ADD5, W_ADD6, "add");
        test_arith(4'b0010, W_SUB5, W_SUB6, "sub");
        test_jz_jmp_out_nop();
        test_halt();
        test_reset_mid_add();
        test_random_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
